// File: rtl/pe_pkg.sv
// Shared definitions for the pipelined MAC processing element: default widths,
// saturation bounds and overflow detection.
package pe_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 24;

  // Widest accumulator the helper functions can describe.
  localparam int unsigned MaxAccW = 64;

  typedef logic [MaxAccW-1:0] bound_t;

  // Saturation bound for a width-bit accumulator, zero-extended to MaxAccW.
  // upper=1 gives the maximum, upper=0 the minimum, for the given signedness.
  function automatic bound_t sat_bound(input int unsigned width, input logic signed_mode,
                                       input logic upper);
    bound_t ones;
    bound_t msb;
    ones = (width >= MaxAccW) ? '1 : ((bound_t'(1) << width) - bound_t'(1));
    msb  = bound_t'(1) << (width - 1);
    if (signed_mode) begin
      return upper ? (ones >> 1) : msb;
    end
    return upper ? ones : '0;
  endfunction

  // Signed: operands of equal sign giving a result of the other sign.
  // Unsigned: carry out of the accumulator width.
  function automatic logic ovf_detect(input logic a_msb, input logic b_msb,
                                      input logic sum_msb, input logic carry,
                                      input logic signed_mode);
    if (signed_mode) begin
      return (a_msb == b_msb) && (sum_msb != a_msb);
    end
    return carry;
  endfunction

endpackage

// File: rtl/pe_acc_stage.sv
// Stage-2 next-state logic: clear priority, accumulate, overflow detection.
// Build option: define PE_MAC_SAT_EN to saturate on overflow instead of wrapping.
module pe_acc_stage
  import pe_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [ACC_W-1:0] prod_i,
  input  logic             prod_vld_i,
  input  logic             clr_i,
  input  logic             signed_mode_i,
  input  logic             ovf_i,
  output logic [ACC_W-1:0] acc_d_o,
  output logic             ovf_d_o
);

  logic [ACC_W:0]   sum;
  logic             ovf_add;
  logic [ACC_W-1:0] add_val;

  // Wide add keeps the carry for unsigned overflow.
  always_comb begin
    sum     = {1'b0, acc_i} + {1'b0, prod_i};
    ovf_add = ovf_detect(acc_i[ACC_W-1], prod_i[ACC_W-1], sum[ACC_W-1], sum[ACC_W],
                         signed_mode_i);
  end

`ifdef PE_MAC_SAT_EN
  // Clamp to the bound in the direction of the overflow.
  always_comb begin
    add_val = sum[ACC_W-1:0];
    if (ovf_add) begin
      if (signed_mode_i && acc_i[ACC_W-1]) begin
        add_val = ACC_W'(sat_bound(ACC_W, 1'b1, 1'b0));
      end else begin
        add_val = ACC_W'(sat_bound(ACC_W, signed_mode_i, 1'b1));
      end
    end
  end
`else
  // Wrap modulo 2^ACC_W.
  always_comb begin
    add_val = sum[ACC_W-1:0];
  end
`endif

  // Clear takes priority; a clear with a valid product starts the tile with it.
  always_comb begin
    acc_d_o = acc_i;
    ovf_d_o = ovf_i;
    if (clr_i && prod_vld_i) begin
      acc_d_o = prod_i;
      ovf_d_o = 1'b0;
    end else if (clr_i) begin
      acc_d_o = '0;
      ovf_d_o = 1'b0;
    end else if (prod_vld_i) begin
      acc_d_o = add_val;
      ovf_d_o = ovf_i | ovf_add;
    end
  end

endmodule

// File: rtl/pe_mac_pipe.sv
// Pipelined output-stationary MAC PE: operand forwarding, stage-1 multiply,
// stage-2 accumulate (pe_acc_stage) and chain readout shift.
// Build option: PE_MAC_SAT_EN selects saturating accumulation (see pe_acc_stage).
module pe_mac_pipe
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_a,
  input  logic              in_a_vld,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_b_vld,
  input  logic              signed_mode,
  input  logic              acc_clr,
  input  logic              chain_en,
  input  logic [ACC_W-1:0]  chain_in,
  output logic [DATA_W-1:0] out_a,
  output logic              out_a_vld,
  output logic [DATA_W-1:0] out_b,
  output logic              out_b_vld,
  output logic [ACC_W-1:0]  out_c,
  output logic              ovf
);

  if (ACC_W < 2 * DATA_W) begin : g_bad_width
    $error("pe_mac_pipe: ACC_W must be >= 2*DATA_W");
  end

  logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic              out_a_vld_q, out_a_vld_d, out_b_vld_q, out_b_vld_d;
  logic [ACC_W-1:0]  prod_q, prod_d, acc_q, acc_d, acc_nxt;
  logic              prod_vld_q, prod_vld_d, clr_q, clr_d, mode_q, mode_d;
  logic              ovf_q, ovf_d, ovf_nxt;

  logic [2*DATA_W-1:0]        prod_u;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [ACC_W-1:0]           prod_ext;

  // Full-width product, extended to the accumulator width per operand signedness.
  always_comb begin
    prod_u = {{DATA_W{1'b0}}, in_a} * {{DATA_W{1'b0}}, in_b};
    prod_s = $signed({{DATA_W{in_a[DATA_W-1]}}, in_a}) *
             $signed({{DATA_W{in_b[DATA_W-1]}}, in_b});
    if (signed_mode) begin
      prod_ext = ACC_W'(prod_s);
    end else begin
      prod_ext = ACC_W'(prod_u);
    end
  end

  pe_acc_stage #(
    .ACC_W(ACC_W)
  ) u_acc_stage (
    .acc_i        (acc_q),
    .prod_i       (prod_q),
    .prod_vld_i   (prod_vld_q),
    .clr_i        (clr_q),
    .signed_mode_i(mode_q),
    .ovf_i        (ovf_q),
    .acc_d_o      (acc_nxt),
    .ovf_d_o      (ovf_nxt)
  );

  // Chain mode overrides everything and kills any product in flight.
  always_comb begin
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_a_vld_d = 1'b0;
    out_b_vld_d = 1'b0;
    prod_d      = prod_q;
    prod_vld_d  = 1'b0;
    clr_d       = 1'b0;
    mode_d      = mode_q;
    acc_d       = chain_in;
    ovf_d       = ovf_q;
    if (!chain_en) begin
      out_a_d     = in_a;
      out_b_d     = in_b;
      out_a_vld_d = in_a_vld;
      out_b_vld_d = in_b_vld;
      prod_d      = prod_ext;
      prod_vld_d  = in_a_vld & in_b_vld;
      clr_d       = acc_clr;
      mode_d      = signed_mode;
      acc_d       = acc_nxt;
      ovf_d       = ovf_nxt;
    end
  end

  // All pipeline state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_a_vld_q <= 1'b0;
      out_b_vld_q <= 1'b0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      clr_q       <= 1'b0;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_a_vld_q <= out_a_vld_d;
      out_b_vld_q <= out_b_vld_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      clr_q       <= clr_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_a_vld = out_a_vld_q;
  assign out_b_vld = out_b_vld_q;
  assign out_c     = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Directed bench for pe_mac_pipe: a 24-bit accumulator instance for the main
// scenarios and a 16-bit instance for overflow, sharing the same stimulus.
module tb_pe_mac_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_a, in_b;
  logic        in_a_vld, in_b_vld, signed_mode, acc_clr, chain_en;
  logic [23:0] chain_in;

  logic [7:0]  out_a, out_b, s_out_a, s_out_b;
  logic        out_a_vld, out_b_vld, s_out_a_vld, s_out_b_vld;
  logic [23:0] out_c;
  logic [15:0] s_out_c;
  logic        ovf, s_ovf;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PE_MAC_SAT_EN
  localparam logic [15:0] OvfExp = 16'hFFFF;
`else
  localparam logic [15:0] OvfExp = 16'h0010;
`endif

  always #5 clk = ~clk;

  pe_mac_pipe #(.DATA_W(8), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_a_vld(in_a_vld), .in_b(in_b),
    .in_b_vld(in_b_vld), .signed_mode(signed_mode), .acc_clr(acc_clr),
    .chain_en(chain_en), .chain_in(chain_in), .out_a(out_a), .out_a_vld(out_a_vld),
    .out_b(out_b), .out_b_vld(out_b_vld), .out_c(out_c), .ovf(ovf)
  );

  pe_mac_pipe #(.DATA_W(8), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_a(in_a), .in_a_vld(in_a_vld), .in_b(in_b),
    .in_b_vld(in_b_vld), .signed_mode(signed_mode), .acc_clr(acc_clr),
    .chain_en(chain_en), .chain_in(chain_in[15:0]), .out_a(s_out_a),
    .out_a_vld(s_out_a_vld), .out_b(s_out_b), .out_b_vld(s_out_b_vld),
    .out_c(s_out_c), .ovf(s_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic av, input logic [7:0] b,
                       input logic bv, input logic clr);
    in_a = a; in_a_vld = av; in_b = b; in_b_vld = bv; acc_clr = clr;
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_c !== 24'd0 || ovf !== 1'b0) begin
      $display("FAIL reset_acc: got c=%h ovf=%b want c=0 ovf=0", out_c, ovf); n_fail++;
    end
    n_checks++;
    if (out_a !== 8'd0 || out_a_vld !== 1'b0 || out_b !== 8'd0 || out_b_vld !== 1'b0) begin
      $display("FAIL reset_fwd: got a=%h/%b b=%h/%b want 0", out_a, out_a_vld, out_b, out_b_vld);
      n_fail++;
    end
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    signed_mode = 1'b0;
    drive(8'd3, 1'b1, 8'd4, 1'b1, 1'b1); tick();
    drive(8'd5, 1'b1, 8'd6, 1'b1, 1'b0); tick();
    n_checks++;
    if (out_c !== 24'd12) begin
      $display("FAIL uns_first: got %0d want 12", out_c); n_fail++;
    end
    drive(8'd255, 1'b1, 8'd255, 1'b1, 1'b0); tick();
    n_checks++;
    if (out_c !== 24'd42) begin
      $display("FAIL uns_second: got %0d want 42", out_c); n_fail++;
    end
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0); tick();
    n_checks++;
    if (out_c !== 24'd65067 || ovf !== 1'b0) begin
      $display("FAIL uns_third: got %0d ovf=%b want 65067 ovf=0", out_c, ovf); n_fail++;
    end
  endtask

  task automatic test_signed();
    signed_mode = 1'b1;
    drive(8'hFD, 1'b1, 8'h04, 1'b1, 1'b1); tick();
    n_checks++;
    if (out_a !== 8'hFD || out_a_vld !== 1'b1 || out_b !== 8'h04 || out_b_vld !== 1'b1) begin
      $display("FAIL sgn_fwd: got a=%h/%b b=%h/%b want fd/1 04/1",
               out_a, out_a_vld, out_b, out_b_vld);
      n_fail++;
    end
    drive(8'h80, 1'b1, 8'h80, 1'b1, 1'b0); tick();
    n_checks++;
    if (out_c !== 24'hFFFFF4) begin
      $display("FAIL sgn_first: got %h want fffff4", out_c); n_fail++;
    end
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0); tick();
    n_checks++;
    if (out_c !== 24'd16372 || ovf !== 1'b0) begin
      $display("FAIL sgn_second: got %0d ovf=%b want 16372 ovf=0", out_c, ovf); n_fail++;
    end
    signed_mode = 1'b0;
  endtask

  task automatic test_partial_valid();
    chain_en = 1'b1; chain_in = 24'd42; tick();
    chain_en = 1'b0;
    drive(8'd9, 1'b1, 8'd7, 1'b0, 1'b0); tick();
    n_checks++;
    if (out_a !== 8'd9 || out_a_vld !== 1'b1 || out_b_vld !== 1'b0) begin
      $display("FAIL partial_fwd: got a=%0d/%b bvld=%b want 9/1 0", out_a, out_a_vld, out_b_vld);
      n_fail++;
    end
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0); tick();
    n_checks++;
    if (out_c !== 24'd42) begin
      $display("FAIL partial_acc: got %0d want 42", out_c); n_fail++;
    end
  endtask

  task automatic test_chain();
    drive(8'd2, 1'b1, 8'd2, 1'b1, 1'b0); tick();
    // Operands stay valid during chain mode; forwarding must still drop them.
    drive(8'h55, 1'b1, 8'h66, 1'b1, 1'b0);
    chain_en = 1'b1; chain_in = 24'h00ABCD; tick();
    n_checks++;
    if (out_c !== 24'h00ABCD) begin
      $display("FAIL chain_load: got %h want 00abcd", out_c); n_fail++;
    end
    n_checks++;
    if (out_a_vld !== 1'b0 || out_b_vld !== 1'b0 || out_a !== 8'd2 || out_b !== 8'd2) begin
      $display("FAIL chain_fwd: got a=%h/%b b=%h/%b want 02/0 02/0",
               out_a, out_a_vld, out_b, out_b_vld);
      n_fail++;
    end
    chain_en = 1'b0;
    drive(8'd1, 1'b1, 8'd1, 1'b1, 1'b0); tick();
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0); tick();
    n_checks++;
    if (out_c !== 24'h00ABCE) begin
      $display("FAIL chain_resume: got %h want 00abce", out_c); n_fail++;
    end
  endtask

  task automatic test_overflow();
    signed_mode = 1'b0;
    chain_en = 1'b1; chain_in = 24'h00FFF0; tick();
    chain_en = 1'b0;
    drive(8'd4, 1'b1, 8'd8, 1'b1, 1'b0); tick();
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0); tick();
    n_checks++;
    if (s_ovf !== 1'b1 || s_out_c !== OvfExp) begin
      $display("FAIL ovf_set: got c=%h ovf=%b want c=%h ovf=1", s_out_c, s_ovf, OvfExp);
      n_fail++;
    end
    tick();
    n_checks++;
    if (s_ovf !== 1'b1) begin
      $display("FAIL ovf_sticky: got %b want 1", s_ovf); n_fail++;
    end
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b1); tick();
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0); tick();
    n_checks++;
    if (s_out_c !== 16'd0 || s_ovf !== 1'b0) begin
      $display("FAIL ovf_clear: got c=%h ovf=%b want 0 0", s_out_c, s_ovf); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    drive(8'd1, 1'b1, 8'd1, 1'b1, 1'b1); tick();
    drive(8'd2, 1'b1, 8'd2, 1'b1, 1'b0); tick();
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (out_c !== 24'd0 || ovf !== 1'b0 || out_a !== 8'd0 || out_a_vld !== 1'b0 ||
        out_b !== 8'd0 || out_b_vld !== 1'b0 || s_out_c !== 16'd0) begin
      $display("FAIL rst_async: got c=%h ovf=%b a=%h/%b b=%h/%b c16=%h want all 0",
               out_c, ovf, out_a, out_a_vld, out_b, out_b_vld, s_out_c);
      n_fail++;
    end
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0); tick();
    #2 rst = 1'b0;
    drive(8'd7, 1'b1, 8'd7, 1'b1, 1'b1); tick();
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0); tick();
    n_checks++;
    if (out_c !== 24'd49 || s_out_c !== 16'd49) begin
      $display("FAIL rst_resume: got %0d/%0d want 49/49", out_c, s_out_c); n_fail++;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_a = '0; in_b = '0; in_a_vld = 1'b0; in_b_vld = 1'b0;
    signed_mode = 1'b0; acc_clr = 1'b0; chain_en = 1'b0; chain_in = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_partial_valid();
    test_chain();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_mac_pipe.md
Name: pe_mac_pipe

Overview:
Parametrised, pipelined output-stationary processing element for the systolic array; successor to the 8-bit single-cycle MAC PE. Forwards A/B operands with valid flags to its neighbours and accumulates A*B into a wide accumulator. Supports signed or unsigned operands, per-tile accumulator clear, a chain shift for result readout, and sticky overflow reporting.

Parameters:
DATA_W, 8, operand width of A and B
ACC_W, 24, accumulator and chain width; must be >= 2*DATA_W (elaboration error otherwise)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_a  in  DATA_W  A operand from west neighbour
in_a_vld  in  1  in_a valid
in_b  in  DATA_W  B operand from north neighbour
in_b_vld  in  1  in_b valid
signed_mode  in  1  1 = two's-complement operands/accumulate, 0 = unsigned
acc_clr  in  1  start new tile; travels with the operands of the same cycle
chain_en  in  1  readout shift mode
chain_in  in  ACC_W  accumulator value from previous PE in the chain
out_a  out  DATA_W  registered in_a to east
out_a_vld  out  1  registered in_a_vld
out_b  out  DATA_W  registered in_b to south
out_b_vld  out  1  registered in_b_vld
out_c  out  ACC_W  accumulator / chain output
ovf  out  1  sticky overflow flag

Behaviour:
- Reset: all outputs and internal registers 0, asynchronously on rst high; release is synchronous to clk.
- Forwarding, when chain_en=0: out_a/out_a_vld <= in_a/in_a_vld and out_b/out_b_vld <= in_b/in_b_vld every cycle, regardless of valid. Latency is 1.
- Stage 1, when chain_en=0: mac_go = in_a_vld & in_b_vld.
  - prod_r <= product, sign- or zero-extended per signed_mode to ACC_W.
  - prod_vld <= mac_go; clr_p <= acc_clr; mode_p <= signed_mode.
  - Only one valid operand: no MAC, forwarding unaffected.
- Stage 2 (accumulate), in priority order:
  - clr_p & prod_vld: acc <= prod_r; ovf <= 0.
  - clr_p only: acc <= 0; ovf <= 0.
  - prod_vld only: acc <= acc + prod_r; overflow rule below.
  - Otherwise acc holds.
- Latency: operands to out_c update is 2 cycles; back-to-back valid pairs every cycle are supported.
- Overflow: unsigned = carry out of ACC_W; signed = operands same sign and result sign differs. On overflow ovf <= 1, sticky until clear or reset.
- Chain mode (chain_en=1) has priority over everything:
  - out_c <= chain_in.
  - prod_vld and clr_p forced to 0, so an in-flight product is discarded.
  - out_a_vld/out_b_vld <= 0; out_a/out_b hold.
  - ovf holds.
- Leaving chain mode: the next cycle is normal stage-1 sampling; the accumulator continues from the shifted-in value.
- out_c is the accumulator register itself (no extra delay).

Optional Feature:
- Macro PE_MAC_SAT_EN.
- Defined: on overflow the accumulator saturates.
  - Unsigned: all ones; on carry.
  - Signed: max positive (0x7F..F) on positive overflow, min negative (0x80..0) on negative overflow.
  - ovf is still set.
- Undefined: the accumulator wraps modulo 2^ACC_W; ovf is still set.

Decomposition:
- Package pe_pkg:
  - DATA_W_DEF = 8 and ACC_W_DEF = 24.
  - A function returning the signed/unsigned saturation bounds for a given width.
  - An overflow-detect function (a, b, sum, signed_mode).
- Sub-module pe_acc_stage: stage-2 add, overflow detect, saturate (under PE_MAC_SAT_EN), clear priority.
- The top level holds stage 1, forwarding and the chain mux.

Test Plan:
1. Unsigned, DATA_W=8, ACC_W=24:
   - Stimulus: acc_clr with pair (3,4), then pairs (5,6) and (255,255), one per cycle.
   - Response: out_c = 12 two cycles after the first pair, then 42, then 65067; ovf = 0.
2. Signed:
   - Stimulus: acc_clr with pair (-3,4), then (-128,-128).
   - Response: out_c = 0xFFFFF4 (-12), then 16372; out_a/out_b echo the inputs 1 cycle later with vld = 1.
3. Partial valid:
   - Stimulus: in_a_vld=1, in_b_vld=0, in_a=9, out_c=42.
   - Response: out_c stays 42; out_a=9 and out_a_vld=1 next cycle; out_b_vld=0.
4. Chain:
   - Stimulus: valid pair (2,2) followed one cycle later by chain_en=1 with chain_in=0x00ABCD.
   - Response: product discarded; out_c = 0x00ABCD; fwd vld = 0.
   - Then chain_en=0 with pair (1,1): out_c = 0x00ABCE.
5. Overflow, ACC_W=16, unsigned:
   - Stimulus: acc=0xFFF0, pair (4,8).
   - Response: ovf=1. With PE_MAC_SAT_EN out_c=0xFFFF; without it out_c=0x0010.
   - A standalone acc_clr then gives out_c=0 and ovf=0.
6. Reset mid-operation:
   - Stimulus: assert rst asynchronously between clock edges during streaming.
   - Response: all outputs 0 immediately. After release, a clr pair (7,7) gives out_c=49 two cycles later.
